// File: rtl/jtag_reg_bank_pkg.sv
// Shared definitions for the JTAG user register bank: FSM state encoding
// and small constant/helper functions used for select decoding and sizing.
// Helper functions operate on vectors up to 32 bits wide, so NREG <= 32.
package jtag_reg_pkg;

   typedef enum logic [0:0] {
      ST_IDLE  = 1'b0,
      ST_ARMED = 1'b1
   } jtag_state_e;

   // Ceiling log2, usable in parameter/localparam expressions.
   function automatic int clog2(input int value);
      int result;
      result = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < value) begin
            result = i + 1;
         end
      end
      return result;
   endfunction

   // True when exactly one bit of the vector is set.
   function automatic logic is_onehot(input logic [31:0] vec);
      return (vec != 32'd0) && ((vec & (vec - 32'd1)) == 32'd0);
   endfunction

   // Position of the set bit of a one-hot vector (highest set bit otherwise).
   function automatic int oh_to_idx(input logic [31:0] vec);
      int result;
      result = 0;
      for (int i = 0; i < 32; i++) begin
         if (vec[i]) begin
            result = i;
         end
      end
      return result;
   endfunction

endpackage

// File: rtl/jtag_reg_bank_if.sv
// BSCAN user-port side of the register bank: the JTAG TAP outputs that drive
// the bank and the serial data returned to the TAP.
interface jtag_reg_bank_if #(
   parameter int NREG = 4
);
   logic            DRCK;
   logic            SEL;
   logic [NREG-1:0] FSEL;
   logic            TDI;
   logic            CAPTURE;
   logic            SHIFT;
   logic            UPDATE;
   logic            TDO;

   // The BSCAN primitive (or a bench standing in for it) drives the TAP side.
   modport master (
      output DRCK, SEL, FSEL, TDI, CAPTURE, SHIFT, UPDATE,
      input  TDO
   );

   // The register bank consumes the TAP signals and returns TDO.
   modport slave (
      input  DRCK, SEL, FSEL, TDI, CAPTURE, SHIFT, UPDATE,
      output TDO
   );
endinterface

// File: rtl/jtag_reg_bank_in_sync.sv
// Multi-bit, STAGES-deep flop synchronizer with synchronous active-low reset.
// All bits move together, so signals sampled in the same cycle stay aligned.
module jtag_in_sync #(
   parameter int WIDTH  = 1,
   parameter int STAGES = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] stage_q [STAGES];
   logic [WIDTH-1:0] stage_d [STAGES];

   // Next value of each stage is the previous stage (first stage takes the pin).
   always_comb begin
      stage_d[0] = d;
      for (int i = 1; i < STAGES; i++) begin
         stage_d[i] = stage_q[i-1];
      end
   end

   // Synchronizer chain; cleared by reset so no stale JTAG edge survives it.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < STAGES; i++) begin
            stage_q[i] <= '0;
         end
      end else begin
         for (int i = 0; i < STAGES; i++) begin
            stage_q[i] <= stage_d[i];
         end
      end
   end

   assign q = stage_q[STAGES-1];

endmodule

// File: rtl/jtag_reg_bank.sv
// Multi-channel JTAG user write/readback register bank in the CLK25 domain.
// NREG registers of WIDTH bits share one shift register; FSEL picks the
// register. Capture loads readback data from PI, update commits only after
// exactly WIDTH shifted bits. Optional macro JTAG_REG_BANK_TMR_EN triplicates
// the PO storage with 2-of-3 voting.
module jtag_reg_bank
   import jtag_reg_pkg::*;
#(
   parameter int                   NREG        = 4,
   parameter int                   WIDTH       = 16,
   parameter logic [NREG*WIDTH-1:0] DEF_VALUE  = {NREG*WIDTH{1'b0}},
   parameter int                   SYNC_STAGES = 2
) (
   input  logic                  CLK25,
   input  logic                  RST_N,
   jtag_reg_bank_if.slave        jtag,
   input  logic [NREG*WIDTH-1:0] PI,
   output logic [NREG*WIDTH-1:0] PO,
   output logic [NREG-1:0]       UPD_STB,
   output logic                  LEN_ERR
);

   localparam int PW     = NREG * WIDTH;
   localparam int SYNC_W = NREG + 6;
   localparam int IDXW   = (NREG > 1) ? clog2(NREG) : 1;
   localparam int CNTW   = clog2(WIDTH + 2);
   localparam logic [CNTW-1:0] CNT_FULL = CNTW'(WIDTH);
   localparam logic [CNTW-1:0] CNT_SAT  = CNTW'(WIDTH + 1);

   logic [SYNC_W-1:0] sync_in;
   logic [SYNC_W-1:0] sync_out;
   logic              s_drck;
   logic              s_sel;
   logic [NREG-1:0]   s_fsel;
   logic              s_tdi;
   logic              s_capture;
   logic              s_shift;
   logic              s_update;

   assign sync_in = {jtag.DRCK, jtag.SEL, jtag.FSEL, jtag.TDI,
                     jtag.CAPTURE, jtag.SHIFT, jtag.UPDATE};

   jtag_in_sync #(
      .WIDTH  (SYNC_W),
      .STAGES (SYNC_STAGES)
   ) u_in_sync (
      .clk   (CLK25),
      .rst_n (RST_N),
      .d     (sync_in),
      .q     (sync_out)
   );

   assign {s_drck, s_sel, s_fsel, s_tdi, s_capture, s_shift, s_update} = sync_out;

   jtag_state_e       state_q, state_d;
   logic [WIDTH-1:0]  sr_q, sr_d;
   logic [CNTW-1:0]   cnt_q, cnt_d;
   logic [IDXW-1:0]   cidx_q, cidx_d;
   logic              drck_prev_q, drck_prev_d;
   logic              upd_prev_q, upd_prev_d;
   logic [NREG-1:0]   upd_stb_q, upd_stb_d;
   logic              tdo_q, tdo_d;
   logic              len_err_q, len_err_d;
   logic              commit;

   logic              drck_rise;
   logic              upd_rise;
   logic              valid;
   logic [IDXW-1:0]   idx;

   assign drck_rise = s_drck & ~drck_prev_q;
   assign upd_rise  = (s_update & s_sel) & ~upd_prev_q;
   assign valid     = s_sel & is_onehot(32'(s_fsel));
   assign idx       = IDXW'(oh_to_idx(32'(s_fsel)));

   // Transfer sequencing: capture/shift/update decisions and next-state values.
   // An update seen together with a DRCK edge wins and uses the pre-shift data.
   always_comb begin
      state_d     = state_q;
      sr_d        = sr_q;
      cnt_d       = cnt_q;
      cidx_d      = cidx_q;
      len_err_d   = len_err_q;
      upd_stb_d   = '0;
      commit      = 1'b0;
      drck_prev_d = s_drck;
      upd_prev_d  = s_update & s_sel;
      case (state_q)
         ST_IDLE: begin
            if (upd_rise) begin
               len_err_d = 1'b1;
            end else if (drck_rise && s_capture && valid) begin
               sr_d      = PI[idx*WIDTH +: WIDTH];
               cidx_d    = idx;
               cnt_d     = '0;
               len_err_d = 1'b0;
               state_d   = ST_ARMED;
            end
         end
         ST_ARMED: begin
            if (upd_rise) begin
               if (valid && (idx == cidx_q) && (cnt_q == CNT_FULL)) begin
                  commit            = 1'b1;
                  upd_stb_d[cidx_q] = 1'b1;
               end else begin
                  len_err_d = 1'b1;
               end
               state_d = ST_IDLE;
            end else if (drck_rise && s_capture && valid) begin
               sr_d      = PI[idx*WIDTH +: WIDTH];
               cidx_d    = idx;
               cnt_d     = '0;
               len_err_d = 1'b0;
            end else if (drck_rise && s_shift && valid && (idx == cidx_q)) begin
               sr_d  = {s_tdi, sr_q[WIDTH-1:1]};
               cnt_d = (cnt_q == CNT_SAT) ? cnt_q : cnt_q + 1'b1;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
      tdo_d = ((state_q == ST_ARMED) && valid) ? sr_q[0] : 1'b0;
   end

   // Control and shift registers; reset discards any partial transfer.
   always_ff @(posedge CLK25) begin
      if (!RST_N) begin
         state_q     <= ST_IDLE;
         sr_q        <= '0;
         cnt_q       <= '0;
         cidx_q      <= '0;
         drck_prev_q <= 1'b0;
         upd_prev_q  <= 1'b0;
         upd_stb_q   <= '0;
         tdo_q       <= 1'b0;
         len_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         sr_q        <= sr_d;
         cnt_q       <= cnt_d;
         cidx_q      <= cidx_d;
         drck_prev_q <= drck_prev_d;
         upd_prev_q  <= upd_prev_d;
         upd_stb_q   <= upd_stb_d;
         tdo_q       <= tdo_d;
         len_err_q   <= len_err_d;
      end
   end

`ifdef JTAG_REG_BANK_TMR_EN
   (* syn_preserve = 1 *) logic [PW-1:0] po_a_q;
   (* syn_preserve = 1 *) logic [PW-1:0] po_b_q;
   (* syn_preserve = 1 *) logic [PW-1:0] po_c_q;
   logic [PW-1:0] po_vote;
   logic [PW-1:0] po_d;

   assign po_vote = (po_a_q & po_b_q) | (po_a_q & po_c_q) | (po_b_q & po_c_q);

   // Every copy reloads from the vote each cycle, scrubbing single upsets.
   always_comb begin
      po_d = po_vote;
      if (commit) begin
         po_d[cidx_q*WIDTH +: WIDTH] = sr_q;
      end
   end

   // Three identical PO copies.
   always_ff @(posedge CLK25) begin
      if (!RST_N) begin
         po_a_q <= DEF_VALUE;
         po_b_q <= DEF_VALUE;
         po_c_q <= DEF_VALUE;
      end else begin
         po_a_q <= po_d;
         po_b_q <= po_d;
         po_c_q <= po_d;
      end
   end

   assign PO = po_vote;
`else
   logic [PW-1:0] po_q;
   logic [PW-1:0] po_d;

   // PO holds between commits; a commit replaces only the selected slice.
   always_comb begin
      po_d = po_q;
      if (commit) begin
         po_d[cidx_q*WIDTH +: WIDTH] = sr_q;
      end
   end

   // Single PO register.
   always_ff @(posedge CLK25) begin
      if (!RST_N) begin
         po_q <= DEF_VALUE;
      end else begin
         po_q <= po_d;
      end
   end

   assign PO = po_q;
`endif

   assign UPD_STB  = upd_stb_q;
   assign LEN_ERR  = len_err_q;
   assign jtag.TDO = tdo_q;

endmodule
